// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding a first-word-fall-through byte FIFO with W1C status.
// Define UART_RX_PARITY_EN to add an even-parity bit and the sticky perr status flag.
module uart_rx #(
   parameter int CLKDIV  = 16,
   parameter int FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       cs,
   input  logic       addr,
   input  logic       re,
   input  logic       we,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       valid,
   output logic       irq
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [15:0] HALF_BIT = 16'(CLKDIV / 2 - 1);
   localparam logic [15:0] FULL_BIT = 16'(CLKDIV - 1);
   localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
   localparam logic [FIFO_AW:0]   CNT_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_BREAK
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               sync1_q, rxs_q;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic               push, push_ok, pop, full, frame_set, sts_wr;
   logic [7:0]         status;
   logic [7:0]         mem [DEPTH];
   logic               unused_wdata;
`ifdef UART_RX_PARITY_EN
   logic               perr_q, perr_d, par_bad_q, par_bad_d, perr_set;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_set  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rxs_q) begin
               state_d = S_START;
               cnt_d   = HALF_BIT;
            end
         end
         S_START: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (rxs_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DATA;
               cnt_d   = FULL_BIT;
               bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               shift_d[bit_q] = rxs_q;
               cnt_d          = FULL_BIT;
               bit_d          = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               par_bad_d = rxs_q ^ (^shift_q);
               perr_set  = par_bad_d;
               cnt_d     = FULL_BIT;
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
               push = ~par_bad_q;
`else
               push = 1'b1;
`endif
               state_d = S_IDLE;
            end else begin
               // A low stop bit is reported once; BREAK absorbs the rest of a held-low line.
               frame_set = 1'b1;
               state_d   = S_BREAK;
            end
         end
         S_BREAK: begin
            if (rxs_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop      = cs & re & ~addr & (count_q != '0);
      full     = count_q[FIFO_AW];
      // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
      push_ok  = push & (~full | pop);
      sts_wr   = cs & we & addr;
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (push_ok & ~pop) count_d = count_q + CNT_ONE;
      else if (pop & ~push_ok) count_d = count_q - CNT_ONE;
      overrun_d   = (overrun_q & ~(sts_wr & wdata[1])) | (push & ~push_ok);
      frame_err_d = (frame_err_q & ~(sts_wr & wdata[2])) | frame_set;
`ifdef UART_RX_PARITY_EN
      perr_d      = (perr_q & ~(sts_wr & wdata[3])) | perr_set;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q      <= 1'b0;
         par_bad_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         sync1_q     <= rx;
         rxs_q       <= sync1_q;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         perr_q      <= perr_d;
         par_bad_q   <= par_bad_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= shift_q;
   end

   assign valid = (count_q != '0);

`ifdef UART_RX_PARITY_EN
   assign status       = {4'b0, perr_q, frame_err_q, overrun_q, valid};
   assign irq          = valid | overrun_q | frame_err_q | perr_q;
   assign unused_wdata = ^{wdata[7:4], wdata[0]};
`else
   assign status       = {5'b0, frame_err_q, overrun_q, valid};
   assign irq          = valid | overrun_q | frame_err_q;
   assign unused_wdata = ^{wdata[7:3], wdata[0]};
`endif

   always_comb begin
      rdata = 8'h00;
      if (cs) begin
         if (addr) rdata = status;
         else if (valid) rdata = mem[rd_ptr_q];
      end
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped UART receiver; companion to the existing transmit-only uart on the 0xE region.
- Deserialises an 8N1 serial line into bytes and buffers them in a small FIFO.
- The CPU pops bytes through the same data-bus read path, as {24'b0, rdata}.
- Exposes valid, overrun and framing status for polled receive.

Parameters:
- CLKDIV, 16: clocks per bit period; legal range 4..65535.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW (16 entries).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial input, asynchronous to clk; idle level 1.
- cs  input  1  chip select, decoded externally from address[31:28].
- addr  input  1  register select: 0 = DATA, 1 = STATUS.
- re  input  1  read strobe; pops the FIFO on a DATA read.
- we  input  1  write strobe; only STATUS is writable.
- wdata  input  8  write data (STATUS W1C).
- rdata  output  8  combinational read mux.
- valid  output  1  FIFO non-empty.
- irq  output  1  valid | overrun | frame_err.

Behaviour:
- Reset (async): FSM=IDLE, FIFO empty, overrun=0, frame_err=0, synchroniser flops=1, bit/clk counters=0.
  - Outputs during reset: valid=0, irq=0; rdata=8'h00 (empty DATA read returns 0).
- Synchroniser: 2 flops on rx; all logic uses the second flop (rxs). rxs lags rx by 2 clocks.
- FSM states: IDLE, START, DATA, STOP, (PARITY with option), BREAK.
  - IDLE: rxs==0 -> START, cnt=CLKDIV/2-1.
  - START: at cnt==0 sample rxs.
    - If 1, false start -> IDLE.
    - If 0 -> DATA, cnt=CLKDIV-1, bit=0.
  - DATA: at cnt==0 shift rxs into bit[bit] (LSB first), reload cnt=CLKDIV-1.
    - After bit 7 -> STOP, or PARITY with option.
  - STOP: at cnt==0 sample rxs.
    - If 1: push byte -> IDLE.
    - If 0: frame_err=1, byte discarded -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. A held-low line yields exactly one frame_err.
- Sampling: all samples land mid-bit. Push occurs on the clock of the stop-bit sample; valid rises the next cycle.
- FIFO, first-word-fall-through:
  - DATA read returns the head byte combinationally.
  - cs&re&addr==0 with FIFO non-empty pops at the clock edge.
  - A pop while empty does nothing and returns 8'h00.
- FIFO boundaries:
  - Push while full: byte dropped, overrun=1, contents untouched.
  - Push and pop in the same cycle when full: pop frees an entry, push accepted, no overrun.
  - Simultaneous push and pop otherwise: count unchanged.
  - Pointers are FIFO_AW bits and wrap modulo depth.
  - Count is FIFO_AW+1 bits, range 0..depth.
- STATUS read: {5'b0, frame_err, overrun, valid}. Reading STATUS has no side effects.
- STATUS write (cs&we&addr==1):
  - wdata[1]=1 clears overrun; wdata[2]=1 clears frame_err; other bits ignored.
  - A set and a clear in the same cycle: set wins.
- cs&we&addr==0 ignored.
- cs==0: rdata=8'h00; re and we ignored.
- Reset mid-frame: the partial byte is lost. After reset the FSM waits in IDLE for the next falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - After bit 7, the PARITY state samples one extra bit at mid-bit.
  - Even parity is checked against the XOR of the data bits.
  - On mismatch: sticky perr=1, byte discarded; the stop bit is still checked.
  - STATUS bit3 = perr, W1C via wdata[3]; irq also ORs perr.
- When undefined: no PARITY state, STATUS bit3 reads 0, 8N1 only.

Test Plan:
- Byte receive: CLKDIV=16, send 0xA5 8N1 (160 clk frame), no reads.
  - valid=1 one clock after the stop-bit sample; DATA read = 0xA5.
  - After the pop, valid=0 and STATUS=0x00.
- False start: 3-clock low glitch on rx while idle.
  - FSM returns to IDLE, no push, STATUS=0x00.
  - A following 0x3C is received correctly.
- Framing error: send 0x55 with stop bit 0, then rx held low 50 bit times, then high.
  - FIFO empty; STATUS=0x04 with exactly one frame_err.
  - Write 0x04 -> STATUS=0x00.
- Overflow: send 17 bytes 0x00..0x10 without reading.
  - STATUS=0x03; 16 pops return 0x00..0x0F, then valid=0.
  - Write 0x02 clears overrun.
- Push/pop collision: FIFO full, pop asserted on the same clock as the 17th byte's push.
  - overrun stays 0; drain yields bytes 0x01..0x10.
- Reset mid-frame: assert reset during data bit 4 of 0xFF.
  - All outputs 0, no byte pushed.
  - The next frame 0x81 is received correctly.
